ct_mmu_sysmap_req: RTL and testbench

Two-requester front end and result pipeline for the MMU system-map lookup. It accepts physical-page lookup requests from the page-table walker (requester 0) and the JTLB refill path (requester 1), arbitrating between them round-robin. It registers the winning page number onto `mmu_sysmap_pa_y` of the combinational sysmap comparator. It then captures `sysmap_mmu_flg_y` / `sysmap_mmu_hit_y` into a response register with valid/ready backpressure. It sits directly upstream and downstream of the sysmap comparator inside the MMU.

---
 rtl/ct_mmu_sysmap_req.sv | 104 ++++++++++
 tb/tb_ct_mmu_sysmap_req.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ct_mmu_sysmap_req.sv
// Round-robin front end and two-stage result pipeline around the MMU sysmap comparator.
// S1 drives the comparator page number and S2 holds the captured response under backpressure.
module ct_mmu_sysmap_req #(
    parameter int ADDR_WIDTH = 28,
    parameter int FLG_WIDTH  = 5
) (
    input  logic                  forever_cpuclk,
    input  logic                  cpurst,
    input  logic                  rq0_vld,
    input  logic [ADDR_WIDTH-1:0] rq0_pa,
    output logic                  rq0_rdy,
    input  logic                  rq1_vld,
    input  logic [ADDR_WIDTH-1:0] rq1_pa,
    output logic                  rq1_rdy,
    input  logic                  sysmap_kill,
    output logic [ADDR_WIDTH-1:0] mmu_sysmap_pa_y,
    input  logic [FLG_WIDTH-1:0]  sysmap_mmu_flg_y,
    input  logic [7:0]            sysmap_mmu_hit_y,
    output logic                  rsp_vld,
    input  logic                  rsp_rdy,
    output logic                  rsp_id,
    output logic [FLG_WIDTH-1:0]  rsp_flg,
    output logic [2:0]            rsp_idx,
    output logic                  rsp_dflt
);

    logic       s1_vld;
    logic       s1_id;
    logic       rr_ptr;
    logic       s2_free;
    logic       s1_adv;
    logic       s1_free;
    logic       can_acc;
    logic       gnt0;
    logic       gnt1;
    logic       acc;
    logic       hit_one;
    logic [2:0] hit_idx;

    assign s2_free = !rsp_vld || rsp_rdy;
    assign s1_adv  = s1_vld && s2_free;
    assign s1_free = !s1_vld || s1_adv;
    assign can_acc = s1_free && !sysmap_kill;

    // A lone requester wins outright; rr_ptr only breaks ties.
    assign gnt0    = rq0_vld && (!rq1_vld || !rr_ptr);
    assign gnt1    = rq1_vld && (!rq0_vld ||  rr_ptr);
    assign rq0_rdy = can_acc && gnt0;
    assign rq1_rdy = can_acc && gnt1;
    assign acc     = rq0_rdy || rq1_rdy;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        hit_idx = '0;
        for (int i = 0; i < 8; i++) begin
            if (sysmap_mmu_hit_y[i]) hit_idx = 3'(i);
        end
    end

    // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
    assign hit_one = (sysmap_mmu_hit_y != 8'd0) &&
                     ((sysmap_mmu_hit_y & (sysmap_mmu_hit_y - 8'd1)) == 8'd0);

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge forever_cpuclk or posedge cpurst) begin
        if (cpurst) begin
            s1_vld          <= 1'b0;
            s1_id           <= 1'b0;
            rr_ptr          <= 1'b0;
            mmu_sysmap_pa_y <= '0;
        end else if (sysmap_kill) begin
            s1_vld <= 1'b0;
        end else if (acc) begin
            s1_vld          <= 1'b1;
            s1_id           <= rq1_rdy;
            mmu_sysmap_pa_y <= rq1_rdy ? rq1_pa : rq0_pa;
            rr_ptr          <= rq0_rdy;
        end else if (s1_adv) begin
            s1_vld <= 1'b0;
        end
    end

    // Kill leaves the response data untouched; only the valid is dropped.
    always_ff @(posedge forever_cpuclk or posedge cpurst) begin
        if (cpurst) begin
            rsp_vld  <= 1'b0;
            rsp_id   <= 1'b0;
            rsp_flg  <= '0;
            rsp_idx  <= '0;
            rsp_dflt <= 1'b0;
        end else if (sysmap_kill) begin
            rsp_vld <= 1'b0;
        end else if (s1_adv) begin
            rsp_vld  <= 1'b1;
            rsp_id   <= s1_id;
            rsp_flg  <= sysmap_mmu_flg_y;
            rsp_idx  <= hit_one ? hit_idx : 3'd0;
            rsp_dflt <= !hit_one;
        end else if (rsp_rdy) begin
            rsp_vld <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ct_mmu_sysmap_req.sv
// Self-checking bench for ct_mmu_sysmap_req: directed scenarios plus a randomized phase,
// all compared against an in-flight queue model of the lookup pipeline.
module tb_ct_mmu_sysmap_req;

    localparam int AW = 28;
    localparam int FW = 5;

    logic          clk = 1'b0;
    logic          cpurst = 1'b1;
    logic          rq0_vld = 1'b0;
    logic [AW-1:0] rq0_pa = '0;
    logic          rq0_rdy;
    logic          rq1_vld = 1'b0;
    logic [AW-1:0] rq1_pa = '0;
    logic          rq1_rdy;
    logic          sysmap_kill = 1'b0;
    logic [AW-1:0] mmu_sysmap_pa_y;
    logic [FW-1:0] sysmap_mmu_flg_y;
    logic [7:0]    sysmap_mmu_hit_y;
    logic          rsp_vld;
    logic          rsp_rdy = 1'b1;
    logic          rsp_id;
    logic [FW-1:0] rsp_flg;
    logic [2:0]    rsp_idx;
    logic          rsp_dflt;

    // Comparator stand-in: a small table indexed by the low page-number bits.
    logic [7:0]    cmp_hit [16];
    logic [FW-1:0] cmp_flg [16];
    assign sysmap_mmu_hit_y = cmp_hit[mmu_sysmap_pa_y[3:0]];
    assign sysmap_mmu_flg_y = cmp_flg[mmu_sysmap_pa_y[3:0]];

    always #5 clk = ~clk;

    ct_mmu_sysmap_req #(.ADDR_WIDTH(AW), .FLG_WIDTH(FW)) dut (
        .forever_cpuclk   (clk),
        .cpurst           (cpurst),
        .rq0_vld          (rq0_vld),
        .rq0_pa           (rq0_pa),
        .rq0_rdy          (rq0_rdy),
        .rq1_vld          (rq1_vld),
        .rq1_pa           (rq1_pa),
        .rq1_rdy          (rq1_rdy),
        .sysmap_kill      (sysmap_kill),
        .mmu_sysmap_pa_y  (mmu_sysmap_pa_y),
        .sysmap_mmu_flg_y (sysmap_mmu_flg_y),
        .sysmap_mmu_hit_y (sysmap_mmu_hit_y),
        .rsp_vld          (rsp_vld),
        .rsp_rdy          (rsp_rdy),
        .rsp_id           (rsp_id),
        .rsp_flg          (rsp_flg),
        .rsp_idx          (rsp_idx),
        .rsp_dflt         (rsp_dflt)
    );

    typedef struct {
        logic          id;
        logic [FW-1:0] flg;
        logic [2:0]    idx;
        logic          dflt;
        int            age;
    } exp_t;

    // Model: ordered list of lookups in flight, the tie-break owner and the last page driven.
    exp_t          q[$];
    bit            prio;
    logic [AW-1:0] last_pa;
    bit            gnt_log[$];
    int            n_consumed;
    int            n_checks = 0;
    int            n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    function automatic exp_t mk(input logic id, input logic [AW-1:0] pa);
        exp_t       e;
        logic [7:0] h;
        h      = cmp_hit[pa[3:0]];
        e.id   = id;
        e.flg  = cmp_flg[pa[3:0]];
        e.dflt = ($countones(h) != 1);
        e.idx  = e.dflt ? 3'd0 : 3'($clog2(h));
        e.age  = 0;
        return e;
    endfunction

    // One clock cycle, entered and left at the falling edge with inputs already driven.
    task automatic cycle();
        bit   ok, e0, e1, ev, cons, kl;
        exp_t ne;
        #1;
        ok = (q.size() < 2 || rsp_rdy) && !sysmap_kill;
        e0 = ok && rq0_vld && (!rq1_vld || !prio);
        e1 = ok && rq1_vld && (!rq0_vld || prio);
        ev = (q.size() >= 2) || (q.size() == 1 && q[0].age >= 1);
        chk("rq0_rdy", 32'(rq0_rdy), 32'(e0));
        chk("rq1_rdy", 32'(rq1_rdy), 32'(e1));
        chk("rsp_vld", 32'(rsp_vld), 32'(ev));
        chk("pa_y", 32'(mmu_sysmap_pa_y), 32'(last_pa));
        if (ev) begin
            chk("rsp_id", 32'(rsp_id), 32'(q[0].id));
            chk("rsp_flg", 32'(rsp_flg), 32'(q[0].flg));
            chk("rsp_idx", 32'(rsp_idx), 32'(q[0].idx));
            chk("rsp_dflt", 32'(rsp_dflt), 32'(q[0].dflt));
        end
        cons = ev && rsp_rdy;
        kl   = sysmap_kill;
        ne   = e1 ? mk(1'b1, rq1_pa) : mk(1'b0, rq0_pa);
        @(posedge clk);
        if (cons) begin
            void'(q.pop_front());
            n_consumed++;
        end
        if (kl) begin
            q.delete();
        end else begin
            foreach (q[i]) q[i].age++;
            if (e0 || e1) begin
                q.push_back(ne);
                last_pa = e1 ? rq1_pa : rq0_pa;
                prio    = e0;
                gnt_log.push_back(e1);
            end
        end
        @(negedge clk);
    endtask

    // Asynchronous reset pulse inside the low phase, checked before any clock edge.
    task automatic do_reset();
        rq0_vld     = 1'b0;
        rq1_vld     = 1'b0;
        sysmap_kill = 1'b0;
        #2;
        cpurst = 1'b1;
        #1;
        chk("rst_rsp_vld", 32'(rsp_vld), 32'd0);
        chk("rst_rsp_id", 32'(rsp_id), 32'd0);
        chk("rst_rsp_flg", 32'(rsp_flg), 32'd0);
        chk("rst_rsp_idx", 32'(rsp_idx), 32'd0);
        chk("rst_rsp_dflt", 32'(rsp_dflt), 32'd0);
        chk("rst_pa_y", 32'(mmu_sysmap_pa_y), 32'd0);
        chk("rst_rq0_rdy", 32'(rq0_rdy), 32'd0);
        chk("rst_rq1_rdy", 32'(rq1_rdy), 32'd0);
        q.delete();
        prio    = 1'b0;
        last_pa = '0;
        @(negedge clk);
        cpurst = 1'b0;
    endtask

    task automatic lookup(input bit id, input logic [AW-1:0] pa);
        rsp_rdy = 1'b1;
        if (id) begin rq1_vld = 1'b1; rq1_pa = pa; end
        else    begin rq0_vld = 1'b1; rq0_pa = pa; end
        cycle();
        rq0_vld = 1'b0;
        rq1_vld = 1'b0;
        cycle();
    endtask

    task automatic drain();
        rq0_vld     = 1'b0;
        rq1_vld     = 1'b0;
        sysmap_kill = 1'b0;
        rsp_rdy     = 1'b1;
        repeat (4) cycle();
    endtask

    initial begin
        int sent, low;
        for (int i = 0; i < 16; i++) begin
            cmp_hit[i] = 8'h01;
            cmp_flg[i] = '0;
        end

        do_reset();

        // Single lookup: page 0x100 maps to table entry 0.
        cmp_hit[0] = 8'h04;
        cmp_flg[0] = 5'b10011;
        rsp_rdy = 1'b1;
        rq0_vld = 1'b1;
        rq0_pa  = 28'h0000100;
        cycle();
        rq0_vld = 1'b0;
        chk("single_pa_t1", 32'(mmu_sysmap_pa_y), 32'h0000100);
        chk("single_vld_t1", 32'(rsp_vld), 32'd0);
        cycle();
        chk("single_vld_t2", 32'(rsp_vld), 32'd1);
        chk("single_id", 32'(rsp_id), 32'd0);
        chk("single_idx", 32'(rsp_idx), 32'd2);
        chk("single_flg", 32'(rsp_flg), 32'b10011);
        chk("single_dflt", 32'(rsp_dflt), 32'd0);
        drain();

        // Round-robin fairness from reset with both requesters held.
        do_reset();
        cmp_hit[1] = 8'h02; cmp_flg[1] = 5'd1;
        cmp_hit[2] = 8'h80; cmp_flg[2] = 5'd2;
        gnt_log.delete();
        rq0_pa  = 28'h11;
        rq1_pa  = 28'h22;
        rq0_vld = 1'b1;
        rq1_vld = 1'b1;
        repeat (6) cycle();
        chk("rr_count", 32'(gnt_log.size()), 32'd6);
        for (int i = 0; i < 6 && i < gnt_log.size(); i++)
            chk($sformatf("rr_gnt%0d", i), 32'(gnt_log[i]), 32'(i % 2));
        drain();

        // Backpressure: rq1 pages 1..4, response side stalled in cycles 3-5.
        for (int i = 1; i <= 4; i++) begin
            cmp_hit[i] = 8'h01 << i;
            cmp_flg[i] = 5'(i + 8);
        end
        sent = 0;
        low = 0;
        n_consumed = 0;
        for (int c = 1; c <= 40 && (sent < 4 || q.size() > 0); c++) begin
            rq1_vld = (sent < 4);
            rq1_pa  = 28'(sent + 1);
            rsp_rdy = !(c >= 3 && c <= 5);
            #1;
            if (rq1_vld && !rq1_rdy) low++;
            if (rq1_vld && rq1_rdy) sent++;
            cycle();
        end
        chk("bp_rdy_low", 32'(low), 32'd3);
        chk("bp_sent", 32'(sent), 32'd4);
        chk("bp_delivered", 32'(n_consumed), 32'd4);
        drain();

        // Default region (no hit) and multi-hit.
        cmp_hit[6] = 8'h00; cmp_flg[6] = 5'b01111;
        lookup(1'b1, 28'h6);
        chk("dflt_vld", 32'(rsp_vld), 32'd1);
        chk("dflt_dflt", 32'(rsp_dflt), 32'd1);
        chk("dflt_idx", 32'(rsp_idx), 32'd0);
        chk("dflt_flg", 32'(rsp_flg), 32'b01111);
        chk("dflt_id", 32'(rsp_id), 32'd1);
        cmp_hit[7] = 8'h0C; cmp_flg[7] = 5'b00101;
        lookup(1'b0, 28'h7);
        chk("multi_dflt", 32'(rsp_dflt), 32'd1);
        chk("multi_idx", 32'(rsp_idx), 32'd0);
        chk("multi_flg", 32'(rsp_flg), 32'b00101);
        drain();

        // Kill with both stages full and a request pending.
        rsp_rdy = 1'b0;
        rq0_vld = 1'b1;
        rq0_pa  = 28'h3;
        cycle();
        rq0_pa  = 28'h4;
        cycle();
        chk("kill_full", 32'(q.size()), 32'd2);
        sysmap_kill = 1'b1;
        #1;
        chk("kill_rdy", 32'(rq0_rdy), 32'd0);
        cycle();
        sysmap_kill = 1'b0;
        rq0_vld = 1'b0;
        chk("kill_rsp_vld", 32'(rsp_vld), 32'd0);
        chk("kill_pa_kept", 32'(mmu_sysmap_pa_y), 32'h4);
        cycle();
        chk("kill_s1_empty", 32'(rsp_vld), 32'd0);
        drain();

        // Randomized traffic with occasional kills against a fresh table.
        for (int i = 0; i < 16; i++) begin
            case ($urandom_range(0, 3))
                0:       cmp_hit[i] = 8'h00;
                1:       cmp_hit[i] = 8'($urandom);
                default: cmp_hit[i] = 8'h01 << $urandom_range(0, 7);
            endcase
            cmp_flg[i] = 5'($urandom);
        end
        repeat (400) begin
            rq0_vld     = ($urandom_range(0, 3) != 0);
            rq1_vld     = ($urandom_range(0, 2) != 0);
            rq0_pa      = 28'($urandom);
            rq1_pa      = 28'($urandom);
            rsp_rdy     = ($urandom_range(0, 3) != 0);
            sysmap_kill = ($urandom_range(0, 15) == 0);
            cycle();
        end
        drain();

        // Reset in the middle of a stream: nothing in flight may emerge.
        rsp_rdy = 1'b0;
        rq1_vld = 1'b1;
        rq1_pa  = 28'h9;
        cycle();
        rq1_pa  = 28'hA;
        cycle();
        do_reset();
        rsp_rdy = 1'b1;
        repeat (3) cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
